// File: rtl/alu_sequencer.sv
// Accumulator-based command sequencer driving a combinational ALU.
// Commands load the accumulator or apply an ALU op (cmd_rep+1) times; the result returns over a response handshake.
module alu_sequencer #(
    parameter int unsigned w = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [w-1:0] cmd_op,
    input  logic [w-1:0] cmd_operand,
    input  logic         cmd_load,
    input  logic [w-1:0] cmd_rep,
    output logic [w-1:0] alu_opcode,
    output logic [w-1:0] alu_a,
    output logic [w-1:0] alu_b,
    output logic         alu_c_in,
    input  logic [w-1:0] alu_y,
    input  logic         alu_c_out,
    input  logic         alu_v,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [w-1:0] rsp_data,
    output logic [3:0]   rsp_flags,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [w-1:0]   acc_q;
    logic [w-1:0]   op_q;
    logic [w-1:0]   b_q;
    logic [w-1:0]   cnt_q;
    logic [3:0]     flags_q;

    // flags_q layout is {c, v, n, z}; z and n always derive from the accumulator value itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            acc_q   <= cmd_operand;
                            flags_q <= {1'b0, 1'b0, cmd_operand[w-1], cmd_operand == '0};
                            state_q <= RESP;
                        end else begin
                            op_q    <= cmd_op;
                            b_q     <= cmd_operand;
                            cnt_q   <= cmd_rep;
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    acc_q   <= alu_y;
                    flags_q <= {alu_c_out, alu_v, alu_y[w-1], alu_y == '0};
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - w'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign alu_a      = acc_q;
    assign alu_opcode = op_q;
    assign alu_b      = b_q;
    assign alu_c_in   = flags_q[3];
    assign rsp_data   = acc_q;
    assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural 3-bit ALU attached.
// Expected responses are queued when commands are accepted and compared when responses appear.
module tb_alu_sequencer;

    localparam int unsigned W = 3;

    localparam logic [W-1:0] ADD_OP      = 3'd0;
    localparam logic [W-1:0] SUB_OP      = 3'd1;
    localparam logic [W-1:0] AND_OP      = 3'd2;
    localparam logic [W-1:0] OR_OP       = 3'd3;
    localparam logic [W-1:0] XOR_OP      = 3'd4;
    localparam logic [W-1:0] NOT_OP      = 3'd5;
    localparam logic [W-1:0] LL_SHIFT_OP = 3'd6;
    localparam logic [W-1:0] LR_SHIFT_OP = 3'd7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_op = '0;
    logic [W-1:0] cmd_operand = '0;
    logic         cmd_load = 1'b0;
    logic [W-1:0] cmd_rep = '0;
    logic [W-1:0] alu_opcode;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_c_in;
    logic [W-1:0] alu_y;
    logic         alu_c_out;
    logic         alu_v;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_flags;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic [3:0]   flags;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] m_acc = '0;
    logic [3:0]   m_flags = '0;

    alu_sequencer #(.w(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .cmd_load    (cmd_load),
        .cmd_rep     (cmd_rep),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c_in    (alu_c_in),
        .alu_y       (alu_y),
        .alu_c_out   (alu_c_out),
        .alu_v       (alu_v),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_flags   (rsp_flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Returns {c_out, v, y}
    function automatic logic [W+1:0] alu_f(input logic [W-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
        logic [W:0]   s;
        logic [W-1:0] y;
        logic         c;
        logic         v;
        s = '0;
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            ADD_OP: begin
                s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                y = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            SUB_OP: begin
                s = {1'b0, a} - {1'b0, b};
                y = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            AND_OP:      y = a & b;
            OR_OP:       y = a | b;
            XOR_OP:      y = a ^ b;
            NOT_OP:      y = ~a;
            LL_SHIFT_OP: y = a << b;
            LR_SHIFT_OP: y = a >> b;
            default:     y = '0;
        endcase
        return {c, v, y};
    endfunction

    always_comb {alu_c_out, alu_v, alu_y} = alu_f(alu_opcode, alu_a, alu_b, alu_c_in);

    task automatic model_push(input logic ld, input logic [W-1:0] op,
                              input logic [W-1:0] operand, input logic [W-1:0] rep);
        logic [W+1:0] r;
        if (ld) begin
            m_acc   = operand;
            m_flags = {2'b00, operand[W-1], operand == '0};
        end else begin
            for (int unsigned i = 0; i <= rep; i++) begin
                r       = alu_f(op, m_acc, operand, m_flags[3]);
                m_acc   = r[W-1:0];
                m_flags = {r[W+1], r[W], r[W-1], r[W-1:0] == '0};
            end
        end
        sb_q.push_back({m_acc, m_flags});
    endtask

    task automatic model_reset();
        m_acc   = '0;
        m_flags = '0;
        sb_q.delete();
    endtask

    function automatic exp_t sb_pop();
        if (sb_q.size() == 0) return '1;
        return sb_q.pop_front();
    endfunction

    task automatic wait_cmd_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout: got %b, want 1", cmd_ready);
        end
    endtask

    task automatic drive_accept(input logic ld, input logic [W-1:0] op,
                                input logic [W-1:0] operand, input logic [W-1:0] rep);
        wait_cmd_ready();
        cmd_valid   = 1'b1;
        cmd_load    = ld;
        cmd_op      = op;
        cmd_operand = operand;
        cmd_rep     = rep;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_push(ld, op, operand, rep);
    endtask

    // Issues one command, waits for its response and acknowledges it; returns observed values
    task automatic do_cmd(input logic ld, input logic [W-1:0] op, input logic [W-1:0] operand,
                          input logic [W-1:0] rep, output int lat,
                          output logic [W-1:0] d, output logic [3:0] f);
        drive_accept(ld, op, operand, rep);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got %b, want 1", rsp_valid);
        end
        d = rsp_data;
        f = rsp_flags;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/vld/busy %b, want 100", {cmd_ready, rsp_valid, busy});
        end
        checks++;
        if ({rsp_data, rsp_flags, alu_a, alu_b, alu_opcode, alu_c_in} !== '0) begin
            errors++;
            $display("FAIL reset_data: got data %b flags %b a %b b %b op %b cin %b, want all 0",
                     rsp_data, rsp_flags, alu_a, alu_b, alu_opcode, alu_c_in);
        end
        rst = 1'b0;
        drive_accept(1'b1, ADD_OP, 3'b101, 3'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 3'b101) begin
            errors++;
            $display("FAIL reset_preload: got vld %b data %b, want 1 101", rsp_valid, rsp_data);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, busy, rsp_data, rsp_flags} !== {3'b100, {W{1'b0}}, 4'b0000}) begin
            errors++;
            $display("FAIL reset_async: got rdy %b vld %b busy %b data %b flags %b, want 1 0 0 000 0000",
                     cmd_ready, rsp_valid, busy, rsp_data, rsp_flags);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_shift();
        int lat;
        logic [W-1:0] d;
        logic [3:0] f;
        exp_t e;
        do_cmd(1'b1, ADD_OP, 3'b001, 3'd0, lat, d, f);
        e = sb_pop();
        checks++;
        if (d !== e.data || f !== e.flags || lat > 1) begin
            errors++;
            $display("FAIL shift_load: got data %b flags %b lat %0d, want %b %b <=1", d, f, lat, e.data, e.flags);
        end
        do_cmd(1'b0, LL_SHIFT_OP, 3'b001, 3'd1, lat, d, f);
        e = sb_pop();
        checks++;
        if (d !== e.data || f !== e.flags) begin
            errors++;
            $display("FAIL shift_rep1: got data %b flags %b, want %b %b", d, f, e.data, e.flags);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL shift_latency: got %0d, want 2", lat);
        end
        do_cmd(1'b0, LL_SHIFT_OP, 3'b001, 3'd0, lat, d, f);
        e = sb_pop();
        checks++;
        if (d !== e.data || f !== e.flags || lat != 1) begin
            errors++;
            $display("FAIL shift_to_zero: got data %b flags %b lat %0d, want %b %b 1", d, f, lat, e.data, e.flags);
        end
    endtask

    task automatic test_xor_exec();
        int lat;
        logic [W-1:0] d;
        logic [3:0] f;
        exp_t e;
        do_cmd(1'b1, ADD_OP, 3'b101, 3'd0, lat, d, f);
        e = sb_pop();
        checks++;
        if (d !== e.data || f !== e.flags) begin
            errors++;
            $display("FAIL xor_load: got data %b flags %b, want %b %b", d, f, e.data, e.flags);
        end
        drive_accept(1'b0, XOR_OP, 3'b011, 3'd1);
        checks++;
        if ({busy, alu_opcode, alu_a, alu_b} !== {1'b1, XOR_OP, 3'b101, 3'b011}) begin
            errors++;
            $display("FAIL xor_exec1: got busy %b op %b a %b b %b, want 1 %b 101 011",
                     busy, alu_opcode, alu_a, alu_b, XOR_OP);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, alu_a, alu_b} !== {1'b0, 3'b110, 3'b011}) begin
            errors++;
            $display("FAIL xor_exec2: got vld %b a %b b %b, want 0 110 011", rsp_valid, alu_a, alu_b);
        end
        @(posedge clk); #1;
        e = sb_pop();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_flags !== e.flags) begin
            errors++;
            $display("FAIL xor_result: got vld %b data %b flags %b, want 1 %b %b",
                     rsp_valid, rsp_data, rsp_flags, e.data, e.flags);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        drive_accept(1'b1, ADD_OP, 3'b010, 3'd0);
        e = sb_pop();
        cmd_valid   = 1'b1;
        cmd_load    = 1'b1;
        cmd_operand = 3'b111;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready} !== 2'b10 || rsp_data !== e.data || rsp_flags !== e.flags) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got vld %b rdy %b data %b flags %b, want 1 0 %b %b",
                         i, rsp_valid, cmd_ready, rsp_data, rsp_flags, e.data, e.flags);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data} !== {2'b10, e.data}) begin
            errors++;
            $display("FAIL backpressure_release: got rdy %b vld %b data %b, want 1 0 %b",
                     cmd_ready, rsp_valid, rsp_data, e.data);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_max_repeat();
        int lat;
        int n;
        logic [W-1:0] d;
        logic [3:0] f;
        logic busy_ok;
        exp_t e;
        do_cmd(1'b1, ADD_OP, 3'b111, 3'd0, lat, d, f);
        e = sb_pop();
        checks++;
        if (d !== e.data || f !== e.flags) begin
            errors++;
            $display("FAIL maxrep_load: got data %b flags %b, want %b %b", d, f, e.data, e.flags);
        end
        drive_accept(1'b0, AND_OP, 3'b111, 3'd7);
        n = 0;
        busy_ok = 1'b1;
        while (rsp_valid !== 1'b1 && n < 300) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 8 || !busy_ok) begin
            errors++;
            $display("FAIL maxrep_cycles: got %0d exec cycles busy_ok %b, want 8 1", n, busy_ok);
        end
        e = sb_pop();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_flags !== e.flags) begin
            errors++;
            $display("FAIL maxrep_result: got vld %b data %b flags %b, want 1 %b %b",
                     rsp_valid, rsp_data, rsp_flags, e.data, e.flags);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [W-1:0] d;
        logic [3:0] f;
        logic saw_valid;
        exp_t e;
        wait_cmd_ready();
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = NOT_OP;
        cmd_rep   = 3'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, busy, cmd_ready, rsp_data, alu_a} !== {3'b001, {W{1'b0}}, {W{1'b0}}}) begin
            errors++;
            $display("FAIL midreset_state: got vld %b busy %b rdy %b data %b a %b, want 0 0 1 000 000",
                     rsp_valid, busy, cmd_ready, rsp_data, alu_a);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        saw_valid = 1'b0;
        repeat (10) begin
            if (rsp_valid !== 1'b0) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL midreset_no_rsp: got rsp_valid 1 after abort, want 0");
        end
        do_cmd(1'b1, ADD_OP, 3'b011, 3'd0, lat, d, f);
        e = sb_pop();
        checks++;
        if (d !== e.data || f !== e.flags) begin
            errors++;
            $display("FAIL midreset_reload: got data %b flags %b, want %b %b", d, f, e.data, e.flags);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] d;
        logic [3:0] f;
        logic ld;
        logic [W-1:0] op;
        logic [W-1:0] opnd;
        logic [W-1:0] rep;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            ld   = ($urandom_range(0, 3) == 0);
            op   = W'($urandom_range(0, 7));
            opnd = W'($urandom_range(0, 7));
            rep  = W'($urandom_range(0, 3));
            do_cmd(ld, op, opnd, rep, lat, d, f);
            e = sb_pop();
            checks++;
            if (d !== e.data || f !== e.flags) begin
                errors++;
                $display("FAIL b2b_data%0d: ld %b op %0d opnd %b rep %0d got %b %b, want %b %b",
                         i, ld, op, opnd, rep, d, f, e.data, e.flags);
            end
            checks++;
            if ((!ld && lat != int'(rep) + 1) || (ld && lat > 1) || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_timing%0d: got lat %0d rdy %b, want lat %0d rdy 1",
                         i, lat, cmd_ready, ld ? 0 : int'(rep) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_xor_exec();
        test_backpressure();
        test_max_repeat();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Accumulator-based command sequencer that drives the combinational `alu` as its initiator. It accepts operation commands over a valid/ready handshake and presents the opcode and operands to the ALU: the accumulator goes on `a`, the command operand on `b`. It writes each ALU result back into the accumulator, optionally repeating the operation several times, then returns the final result and flags over a valid/ready response handshake. It sits between a command source (test driver or microcontroller front end) and the `alu` instance.

## Interface
- `w`, 3, datapath width; must equal the `alu` instance's `w`. Opcode width is also `w`, with codes from package `alu_ops`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  w  `alu_ops` opcode.
- `cmd_operand`  in  w  operand driven on ALU `b` (or load value).
- `cmd_load`  in  1  1 = load `cmd_operand` into accumulator, no ALU op.
- `cmd_rep`  in  w  extra repetitions; op is applied `cmd_rep+1` times.
- `alu_opcode`  out  w  to `alu.opcode`.
- `alu_a`  out  w  to `alu.a` (accumulator).
- `alu_b`  out  w  to `alu.b`.
- `alu_c_in`  out  1  to `alu.c_in` (stored carry flag).
- `alu_y`  in  w  from `alu.y`.
- `alu_c_out`, `alu_v`  in  1 each  from `alu.c_out`, `alu.v`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  w  accumulator value.
- `rsp_flags`  out  4  {c, v, n, z}.
- `busy`  out  1  state != IDLE.

## Operation
- Registers: `acc`, `op_r`, `b_r`, `cnt` (w bits), `flags` (4 bits), `state`.
- Combinational outputs: `alu_a = acc`, `alu_opcode = op_r`, `alu_b = b_r`, `alu_c_in = flags.c`, `rsp_data = acc`, `rsp_flags = flags`.
- `cmd_ready = (state == IDLE)`. `rsp_valid = (state == RESP)`.
- **IDLE:** On `cmd_valid & cmd_ready`:
  - If `cmd_load`: `acc <= cmd_operand`, `z <= (cmd_operand == 0)`, `n <= cmd_operand[w-1]`, `c <= 0`, `v <= 0`. Go to RESP.
  - Otherwise: `op_r <= cmd_op`, `b_r <= cmd_operand`, `cnt <= cmd_rep`. Go to EXEC.
- **EXEC** (one iteration per cycle):
  - `acc <= alu_y`, `z <= (alu_y == 0)`, `n <= alu_y[w-1]`.
  - `c <= alu_c_out`, `v <= alu_v`. Both are sampled verbatim; z and n are computed locally and never taken from the ALU.
  - If `cnt == 0`, go to RESP; else `cnt <= cnt - 1`.
- **RESP:** Hold all registers. On `rsp_ready`, go to IDLE.
- The accumulator and flags persist across commands. Only `cmd_load` or `rst` reinitialises them.
- An opcode outside `alu_ops` is passed through unchanged; the ALU's default behaviour applies.

## Timing
- Reset values (asynchronous, immediate):
  - State: `state` = IDLE; `acc`, `op_r`, `b_r`, `cnt`, `flags` = 0.
  - Outputs: `cmd_ready` = 1, `rsp_valid` = 0, `busy` = 0, `rsp_data` = 0, `rsp_flags` = 0, `alu_*` outputs = 0.
- ALU command accepted at edge E0:
  - EXEC occupies the cycles after edges E0 .. E0+`cmd_rep`.
  - `rsp_valid` rises after edge E0+`cmd_rep`+1, giving a latency of `cmd_rep`+1 cycles.
  - Maximum latency is 2^w cycles (`cmd_rep` = all ones).
- Load command accepted at E0: `rsp_valid` rises after E0+1.
- The ALU path is purely combinational from registers; `alu_y` is sampled at the end of each EXEC cycle.
- Response handshake completes on an edge with `rsp_valid & rsp_ready`. `cmd_ready` rises the following cycle; there is no same-cycle response-to-command bypass. Minimum command-to-command spacing is `cmd_rep`+3 cycles.
- `rsp_ready` held low: RESP is held indefinitely, with `rsp_data`/`rsp_flags` stable and `cmd_ready` = 0.
- `rst` asserted mid-EXEC or mid-RESP: the command is aborted, no response is produced, and all registers return to reset values.
- `cmd_valid` is ignored outside IDLE. Commands are neither queued nor dropped silently: the source must hold them until `cmd_ready`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> `cmd_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0, `rsp_flags` = 0 immediately.
- Load 3'b001, then LL_SHIFT_OP with operand 1, rep 1:
  - Load response: `rsp_data` 001, flags z=0, n=0.
  - Shift response: `rsp_valid` 2 cycles after accept, `rsp_data` 100, n=1, z=0.
  - Follow with LL_SHIFT_OP, operand 1, rep 0 -> `rsp_data` 000, z=1.
- Load 3'b101, then XOR_OP with operand 3'b011, rep 1 -> intermediate 110, final `rsp_data` 101, n=1. Check `alu_a`/`alu_b` on each EXEC cycle.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles after `rsp_valid` -> `rsp_data` stable, `cmd_ready` = 0, and a pending `cmd_valid` is not accepted. Release -> `cmd_ready` = 1 one cycle later.
- Max repeat: load 3'b111, AND_OP with operand 3'b111, rep 7 -> exactly 8 EXEC cycles, `busy` high throughout, `rsp_data` 111.
- Reset mid-operation: NOT_OP with rep 7, assert `rst` during the 4th EXEC cycle -> no `rsp_valid`, `acc` = 0, and the next load command completes normally.
